// File: rtl/seven_seg_scan_driver_if.sv
// Display-word handshake between a producer and seven_seg_scan_driver.
// The producer offers a packed hex word (digit 0 in the low nibble) on in/in_val.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    in_val;
  logic                    in_rdy;
  logic [4*NUM_DIGITS-1:0] in;

  modport master (output in_val, output in, input in_rdy);
  modport slave  (input in_val, input in, output in_rdy);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex seven-segment scanner with frame-aligned word commit.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_driver_if.slave bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_full;

  logic       div_wrap;
  logic       boundary;
  logic [3:0] nibble;
  logic       blank;

  assign div_wrap   = (div == DIV_LAST);
  assign boundary   = div_wrap && (idx == IDX_LAST);
  assign bus.in_rdy = !pend_full;

  // NOTE: every register here is reset asynchronously; non-blocking assignments
  // make all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div        <= div_wrap ? '0 : div + 1'b1;
      frame_done <= boundary;
      if (div_wrap)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      // Commit and accept are mutually exclusive on pend_full, so no priority clash.
      if (boundary && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (bus.in_val && !pend_full) begin
        pend      <= bus.in;
        pend_full <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // A digit is blank when it and every more-significant digit are zero.
  always_comb begin
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && disp[4*k +: 4] != 4'h0)
        lead_zero = 1'b0;
    end
  end

  assign blank = lead_zero && (idx != '0);
`else
  assign blank = 1'b0;
`endif

  // NOTE: defaults first in always_comb so no path can infer a latch.
  always_comb begin
    nibble = 4'h0;
    seg    = 7'b1111111;
    an     = '1;
    nibble = disp[4*int'(idx) +: 4];
    an     = ~(NUM_DIGITS'(1) << idx);
    if (!blank)
      seg = glyph(nibble);
  end

endmodule
